signal_shape_gen: RTL and testbench
===================================

# signal_shape_gen

Parametrised waveform shaper for the DDS datapath. It turns the phase-accumulator output into one of four selectable waveforms: square with programmable duty, sawtooth, triangle, or inverted sawtooth. Amplitude scaling is applied at the output. Configuration writes are held in a shadow register and take effect only at a phase wrap, so the output never glitches mid-period. It sits between the phase accumulator and the DAC output register and replaces the fixed single-shape lookup.

## Interface
- PHASE_W, 14, phase word width; must be ≥ OUT_W+1
- OUT_W, 12, output sample width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- phase  in  PHASE_W  phase word from accumulator
- phase_valid  in  1  phase is a new sample this cycle
- cfg_mode  in  2  0 square, 1 sawtooth, 2 triangle, 3 inverted sawtooth
- cfg_duty  in  PHASE_W  square high threshold
- cfg_amp  in  OUT_W  amplitude, full scale = all ones
- cfg_valid  in  1  capture cfg_* into the shadow register
- cfg_pending  out  1  shadow config is waiting for a wrap
- value  out  OUT_W  shaped, scaled sample
- value_valid  out  1  value is a new sample
- cycle_start  out  1  value is the first sample of a new period

## Operation
- Reset state:
  - Active config: mode 0, duty = 1<<(PHASE_W-1), amp = all ones.
  - Shadow config is cleared; cfg_pending = 0.
  - value = 0, value_valid = 0, cycle_start = 0.
  - last_phase = 0; first flag = 1.
- Shadow config:
  - cfg_valid loads the shadow register and sets cfg_pending.
  - A further cfg_valid while pending overwrites the shadow; last write wins.
- Wrap event: phase_valid && (first || phase < last_phase).
  - On each phase_valid, last_phase is updated and first is cleared.
  - On a wrap with cfg_pending=1, the shadow becomes the active config. That wrap sample already uses the new config, and cfg_pending clears.
  - If cfg_valid and a wrap occur in the same cycle, the wrap uses the previous shadow (if pending) or the unchanged active config. The new write is held and remains pending until the next wrap.
- Stage 1 computes raw (OUT_W bits, unsigned) from the active config:
  - Mode 0: raw = all ones if phase < duty, else 0. duty=0 gives constant 0.
  - Mode 1: raw = phase[PHASE_W-1 -: OUT_W].
  - Mode 2: t = phase[PHASE_W-2 -: OUT_W]; raw = t if phase MSB is 0, else ~t.
  - Mode 3: raw = ~phase[PHASE_W-1 -: OUT_W].
- Stage 2 scales: value = (raw × (amp+1)) >> OUT_W.
  - amp+1 is OUT_W+1 bits wide; the product is 2·OUT_W+1 bits.
  - With amp = all ones the output is exact passthrough.
- The wrap flag travels with the sample and appears as cycle_start.

## Timing
- Latency is 2 cycles. A phase sampled at edge N with phase_valid=1 produces value, value_valid=1 and cycle_start after edge N+2.
- When phase_valid=0, no pipeline state advances for that slot: value holds, and value_valid=0 and cycle_start=0 two cycles later.
- Throughput is one sample per cycle.
- cfg_pending rises the cycle after cfg_valid. It falls the cycle after the wrap sample is accepted.
- Reset mid-operation flushes the pipeline: value_valid=0 and value=0 after the reset edge. In-flight samples and any pending config are discarded.

## Test plan
- **Defaults after reset** (PHASE_W=14, OUT_W=12):
  - phase 0x0000 → value 0xFFF with cycle_start=1.
  - phase 0x1FFF → 0xFFF.
  - phase 0x2000 → 0x000.
  - Each appears 2 cycles after input.
- **Sawtooth** (mode 1, amp 0xFFF):
  - phase 0x1230 → 0x48C.
  - phase 0x3FFF → 0xFFF.
  - Then amp 0x7FF with phase 0x3FFF → 0x7FF.
- **Triangle** (mode 2):
  - phase 0x1000 → 0x800.
  - phase 0x1FFF → 0xFFF.
  - phase 0x3000 → 0x7FF.
  - phase 0x3FFF → 0x000.
- **Deferred config**:
  - Setup: mode 0, phase stepping 0x1000.
  - At phase 0x2000, pulse cfg_valid with mode 1 → cfg_pending=1.
  - Phase 0x3000 still gives 0x000 (square).
  - Phase 0x0000 gives 0x000 with cycle_start=1, and cfg_pending clears.
  - Phase 0x1000 → 0x400.
- **Config edge cases**:
  - Two cfg_valid writes before a wrap → only the second is applied.
  - cfg_valid coincident with a wrap → cfg_pending stays 1 and the config applies at the following wrap.
- **Bubbles and reset**:
  - phase_valid low for 3 cycles → value holds and value_valid is low for 3 cycles.
  - Assert rst with samples in flight → next cycle value=0 and value_valid=0, and cfg_pending=0.

Source files
------------

// File: rtl/signal_shape_gen.sv
// Waveform shaper for the DDS path: square/saw/triangle/inverted saw with amplitude scaling.
// Config writes are shadowed and only become active on a phase wrap.
module signal_shape_gen #(
    parameter int PHASE_W = 14,
    parameter int OUT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] phase,
    input  logic               phase_valid,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_duty,
    input  logic [OUT_W-1:0]   cfg_amp,
    input  logic               cfg_valid,
    output logic               cfg_pending,
    output logic [OUT_W-1:0]   value,
    output logic               value_valid,
    output logic               cycle_start
);

    function automatic logic [OUT_W-1:0] shape(input logic [1:0]         mode,
                                               input logic [PHASE_W-1:0] ph,
                                               input logic [PHASE_W-1:0] duty);
        logic [OUT_W-1:0] r;
        case (mode)
            2'd0:    r = (ph < duty) ? '1 : '0;
            2'd1:    r = ph[PHASE_W-1 -: OUT_W];
            2'd2:    r = ph[PHASE_W-1] ? ~ph[PHASE_W-2 -: OUT_W] : ph[PHASE_W-2 -: OUT_W];
            default: r = ~ph[PHASE_W-1 -: OUT_W];
        endcase
        return r;
    endfunction

    // amp+1 makes all-ones amplitude an exact passthrough after the shift.
    function automatic logic [OUT_W-1:0] scale(input logic [OUT_W-1:0] raw,
                                               input logic [OUT_W-1:0] amp);
        logic [OUT_W:0]   amp1;
        logic [2*OUT_W:0] prod;
        amp1 = {1'b0, amp} + (OUT_W+1)'(1);
        prod = (2*OUT_W+1)'(raw) * (2*OUT_W+1)'(amp1);
        return OUT_W'(prod >> OUT_W);
    endfunction

    logic [1:0]         act_mode, sh_mode, sel_mode, mode_p0;
    logic [PHASE_W-1:0] act_duty, sh_duty, sel_duty, duty_p0;
    logic [OUT_W-1:0]   act_amp, sh_amp, sel_amp, amp_p0, amp_p1;
    logic [PHASE_W-1:0] last_phase, phase_p0;
    logic [OUT_W-1:0]   raw_p1;
    logic               first, wrap, take_shadow;
    logic               vld_p0, vld_p1, vld_p2;
    logic               wrap_p0, wrap_p1, wrap_p2;

    always_comb begin
        wrap        = phase_valid && (first || (phase < last_phase));
        take_shadow = wrap && cfg_pending;
        sel_mode    = take_shadow ? sh_mode : act_mode;
        sel_duty    = take_shadow ? sh_duty : act_duty;
        sel_amp     = take_shadow ? sh_amp  : act_amp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_mode    <= 2'd0;
            act_duty    <= PHASE_W'(1) << (PHASE_W-1);
            act_amp     <= '1;
            sh_mode     <= 2'd0;
            sh_duty     <= '0;
            sh_amp      <= '0;
            cfg_pending <= 1'b0;
            first       <= 1'b1;
            last_phase  <= '0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            wrap_p0     <= 1'b0;
            wrap_p1     <= 1'b0;
            wrap_p2     <= 1'b0;
            value       <= '0;
        end else begin
            if (take_shadow) begin
                act_mode <= sh_mode;
                act_duty <= sh_duty;
                act_amp  <= sh_amp;
            end
            // A write landing on a wrap is kept for the following wrap.
            if (cfg_valid) begin
                sh_mode     <= cfg_mode;
                sh_duty     <= cfg_duty;
                sh_amp      <= cfg_amp;
                cfg_pending <= 1'b1;
            end else if (wrap) begin
                cfg_pending <= 1'b0;
            end
            if (phase_valid) begin
                last_phase <= phase;
                first      <= 1'b0;
            end
            vld_p0  <= phase_valid;
            wrap_p0 <= wrap;
            vld_p1  <= vld_p0;
            wrap_p1 <= wrap_p0;
            vld_p2  <= vld_p1;
            wrap_p2 <= wrap_p1;
            if (vld_p1) value <= scale(raw_p1, amp_p1);
        end
    end

    always_ff @(posedge clk) begin
        // p0: captured phase with the config that applies to it
        if (phase_valid) begin
            phase_p0 <= phase;
            mode_p0  <= sel_mode;
            duty_p0  <= sel_duty;
            amp_p0   <= sel_amp;
        end
        // p1: unscaled waveform sample
        if (vld_p0) begin
            raw_p1 <= shape(mode_p0, phase_p0, duty_p0);
            amp_p1 <= amp_p0;
        end
    end

    assign value_valid = vld_p2;
    assign cycle_start = wrap_p2;

endmodule

// File: tb/tb_signal_shape_gen.sv
// Randomized + directed bench for signal_shape_gen against a per-sample reference model.
module tb_signal_shape_gen;
    localparam int PW = 14;
    localparam int OW = 12;
    localparam int FS = (1 << OW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] phase = '0;
    logic          phase_valid = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [PW-1:0] cfg_duty = '0;
    logic [OW-1:0] cfg_amp = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_pending;
    logic [OW-1:0] value;
    logic          value_valid;
    logic          cycle_start;

    always #5 clk = ~clk;

    signal_shape_gen #(.PHASE_W(PW), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .phase(phase), .phase_valid(phase_valid),
        .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_amp(cfg_amp), .cfg_valid(cfg_valid),
        .cfg_pending(cfg_pending), .value(value), .value_valid(value_valid),
        .cycle_start(cycle_start)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction-level config state and expected output per input slot.
    typedef struct {bit vld; int val; bit cs;} exp_t;
    exp_t q[$];
    int   a_mode, a_duty, a_amp, s_mode, s_duty, s_amp, m_last, held;
    bit   m_pend, m_first;

    function automatic int ref_value(int mode, int duty, int amp, int ph);
        int raw;
        int t;
        case (mode)
            0: raw = (ph < duty) ? FS : 0;
            1: raw = ph >> (PW - OW);
            2: begin
                t   = (ph >> (PW - OW - 1)) % (1 << OW);
                raw = (ph >= (1 << (PW - 1))) ? FS - t : t;
            end
            default: raw = FS - (ph >> (PW - OW));
        endcase
        return (raw * (amp + 1)) >> OW;
    endfunction

    task automatic step(input bit r, input bit pv, input int ph, input bit cv,
                        input int m, input int d, input int a);
        exp_t e;
        exp_t z;
        exp_t o;
        bit   wrap;
        rst         = r;
        phase_valid = pv;
        phase       = PW'(ph);
        cfg_valid   = cv;
        cfg_mode    = 2'(m);
        cfg_duty    = PW'(d);
        cfg_amp     = OW'(a);
        @(posedge clk);
        #1;
        if (r) begin
            a_mode = 0; a_duty = 1 << (PW - 1); a_amp = FS;
            s_mode = 0; s_duty = 0; s_amp = 0;
            m_pend = 0; m_first = 1; m_last = 0; held = 0;
            z = '{vld: 0, val: 0, cs: 0};
            q.delete();
            repeat (3) q.push_back(z);
        end else begin
            wrap = pv && (m_first || ph < m_last);
            if (wrap && m_pend) begin
                a_mode = s_mode; a_duty = s_duty; a_amp = s_amp;
            end
            if (pv) begin
                held    = ref_value(a_mode, a_duty, a_amp, ph);
                m_last  = ph;
                m_first = 0;
            end
            e = '{vld: pv, val: held, cs: wrap};
            if (cv) begin
                s_mode = m; s_duty = d; s_amp = a; m_pend = 1;
            end else if (wrap) begin
                m_pend = 0;
            end
            q.push_back(e);
        end
        o = q[q.size() - 3];
        check("value", value, o.val);
        check("value_valid", value_valid, o.vld);
        check("cycle_start", cycle_start, o.cs);
        check("cfg_pending", cfg_pending, m_pend);
    endtask

    task automatic bubble();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int m, input int d, input int a);
        step(0, 0, 0, 1, m, d, a);
    endtask

    task automatic sample_cfg(input string tag, input int ph, input bit cv, input int m,
                              input int d, input int a, input int expv, input bit expcs);
        step(0, 1, ph, cv, m, d, a);
        bubble();
        bubble();
        check({tag, "_val"}, value, expv);
        check({tag, "_cs"}, cycle_start, expcs);
        check({tag, "_vld"}, value_valid, 1);
    endtask

    task automatic sample(input string tag, input int ph, input int expv, input bit expcs);
        sample_cfg(tag, ph, 0, 0, 0, 0, expv, expcs);
    endtask

    initial begin
        int  acc;
        bit  r, pv, cv;
        int  m, d, a;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_value", value, 0);
        check("rst_vld", value_valid, 0);
        check("rst_pend", cfg_pending, 0);

        sample("def0", 16'h0000, 12'hFFF, 1);
        sample("def1", 16'h1FFF, 12'hFFF, 0);
        sample("def2", 16'h2000, 12'h000, 0);

        cfg(1, 16'h2000, 12'hFFF);
        sample("saw0", 16'h0000, 12'h000, 1);
        sample("saw1", 16'h1230, 12'h48C, 0);
        sample("saw2", 16'h3FFF, 12'hFFF, 0);
        cfg(1, 16'h2000, 12'h7FF);
        sample("saw3", 16'h0000, 12'h000, 1);
        sample("saw4", 16'h3FFF, 12'h7FF, 0);

        cfg(2, 16'h2000, 12'hFFF);
        sample("tri0", 16'h0000, 12'h000, 1);
        sample("tri1", 16'h1000, 12'h800, 0);
        sample("tri2", 16'h1FFF, 12'hFFF, 0);
        sample("tri3", 16'h3000, 12'h7FF, 0);
        sample("tri4", 16'h3FFF, 12'h000, 0);

        cfg(0, 16'h2000, 12'hFFF);
        sample("dfr0", 16'h0000, 12'hFFF, 1);
        sample("dfr1", 16'h1000, 12'hFFF, 0);
        sample_cfg("dfr2", 16'h2000, 1, 1, 16'h2000, 12'hFFF, 12'h000, 0);
        check("dfr_pend_set", cfg_pending, 1);
        sample("dfr3", 16'h3000, 12'h000, 0);
        sample("dfr4", 16'h0000, 12'h000, 1);
        check("dfr_pend_clr", cfg_pending, 0);
        sample("dfr5", 16'h1000, 12'h400, 0);

        cfg(3, 16'h2000, 12'hFFF);
        cfg(1, 16'h2000, 12'hFFF);
        sample("two0", 16'h0000, 12'h000, 1);
        sample("two1", 16'h1000, 12'h400, 0);

        sample("co0", 16'h3000, 12'hC00, 0);
        sample_cfg("co1", 16'h0000, 1, 3, 16'h2000, 12'hFFF, 12'h000, 1);
        check("co_pend_held", cfg_pending, 1);
        sample("co2", 16'h1000, 12'h400, 0);
        sample("co3", 16'h0000, 12'hFFF, 1);
        check("co_pend_clr", cfg_pending, 0);

        bubble();
        check("hold_val", value, 12'hFFF);
        check("hold_vld", value_valid, 0);

        cfg(1, 16'h2000, 12'hFFF);
        step(0, 1, 16'h0100, 0, 0, 0, 0);
        step(0, 1, 16'h0200, 0, 0, 0, 0);
        step(1, 1, 16'h0300, 0, 0, 0, 0);
        check("midrst_val", value, 0);
        check("midrst_vld", value_valid, 0);
        check("midrst_pend", cfg_pending, 0);

        acc = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            pv = ($urandom_range(0, 9) < 8);
            cv = ($urandom_range(0, 24) == 0);
            m  = int'($urandom_range(0, 3));
            d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, (1 << PW) - 1));
            a  = ($urandom_range(0, 3) == 0) ? FS : int'($urandom_range(0, FS));
            if (pv) acc = (acc + int'($urandom_range(1, 6000))) % (1 << PW);
            step(r, pv, acc, cv, m, d, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
